// File: rtl/vpu_lane_result_collector_pkg.sv
// Shared types and constants for the VPU lane result collector.
//   VPU_OPERAND_WIDTH  - lane result width
//   VPU_MAX_DELAY_LG2  - width of the issue delay field
//   VPU_TAG_WIDTH      - destination/ID tag width
//   RESULT_FIFO_DEPTH  - result buffer entries (power of 2, >= 2)
//   vpu_delay_t        - issue delay
//   vpu_wb_entry_t     - one buffered writeback entry {tag, data}
package vpu_lane_result_collector_pkg;

    localparam int VPU_OPERAND_WIDTH = 32;
    localparam int VPU_MAX_DELAY_LG2 = 3;
    localparam int VPU_TAG_WIDTH     = 5;
    localparam int RESULT_FIFO_DEPTH = 4;

    typedef logic [VPU_MAX_DELAY_LG2-1:0] vpu_delay_t;

    typedef struct packed {
        logic [VPU_TAG_WIDTH-1:0]     tag;
        logic [VPU_OPERAND_WIDTH-1:0] data;
    } vpu_wb_entry_t;

endpackage

// File: rtl/vpu_sync_fifo.sv
// Synchronous FIFO with registered storage; the head entry is presented
// directly on dout_o. Reusable by any VPU stage.
//   clk, rst   - clock, synchronous active-high reset (clears storage too)
//   push_i     - write din_i at the edge (ignored when full)
//   din_i      - write data
//   pop_i      - drop the head entry at the edge (ignored when empty)
//   dout_o     - head entry
//   full_o     - count == DEPTH
//   empty_o    - count == 0
//   count_o    - number of stored entries
module vpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == (AW+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign dout_o  = r_mem[r_rd_ptr];

    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din_i;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vpu_lane_result_collector.sv
// Collects VPU lane results: tracks each issued op with its latency, samples
// the lane result bus on the op's completion cycle, tags it and buffers it in
// a FIFO that drains to writeback. Issue is throttled so no completion is lost.
//   clk, rst        - clock, synchronous active-high reset
//   issue_valid_i   - op issued to the lane this cycle
//   issue_delay_i   - cycles until the lane result is valid (0 = same cycle)
//   issue_tag_i     - ID returned with the result
//   issue_ready_o   - issue accepted this cycle (combinational)
//   lane_dout_i     - lane result bus
//   wb_valid_o      - writeback head valid
//   wb_data_o       - writeback head data
//   wb_tag_o        - writeback head tag
//   wb_ready_i      - writeback consumes the head when wb_valid_o & wb_ready_i
//   inflight_o      - issued ops not yet captured
//   busy_o          - ops in flight or results buffered
//
// Handshakes: issue transfers when issue_valid_i & issue_ready_o; the issuer
// holds valid/delay/tag until that happens. Writeback transfers when
// wb_valid_o & wb_ready_i; head data/tag are stable while stalled.
module vpu_lane_result_collector
    import vpu_lane_result_collector_pkg::*;
#(
    parameter int OPERAND_WIDTH = VPU_OPERAND_WIDTH,
    parameter int MAX_DELAY_LG2 = VPU_MAX_DELAY_LG2,
    parameter int TAG_WIDTH     = VPU_TAG_WIDTH,
    parameter int FIFO_DEPTH    = RESULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid_i,
    input  logic [MAX_DELAY_LG2-1:0] issue_delay_i,
    input  logic [TAG_WIDTH-1:0]     issue_tag_i,
    output logic                     issue_ready_o,
    input  logic [OPERAND_WIDTH-1:0] lane_dout_i,
    output logic                     wb_valid_o,
    output logic [OPERAND_WIDTH-1:0] wb_data_o,
    output logic [TAG_WIDTH-1:0]     wb_tag_o,
    input  logic                     wb_ready_i,
    output logic [MAX_DELAY_LG2:0]   inflight_o,
    output logic                     busy_o
);

    localparam int NSLOT = 1 << MAX_DELAY_LG2;
    localparam int PW    = MAX_DELAY_LG2 + 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int EW    = TAG_WIDTH + OPERAND_WIDTH;

    // Pending line: r_pend[k] set means capture lane_dout_i k cycles from now
    // and attach r_tag[k].
    logic [NSLOT-1:0]     r_pend;
    logic [TAG_WIDTH-1:0] r_tag [NSLOT];
    logic [PW-1:0]        r_inflight;

    logic [NSLOT-1:0]     w_pend_nxt;
    logic [TAG_WIDTH-1:0] w_tag_nxt [NSLOT];
    logic [PW-1:0]        w_pcount;
    logic                 w_credit_ok;
    logic                 w_acc;
    logic                 w_cap;
    logic [TAG_WIDTH-1:0] w_cap_tag;
    logic [EW-1:0]        w_fifo_din;
    logic [EW-1:0]        w_fifo_dout;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CW-1:0]        w_fifo_cnt;

    function automatic logic [PW-1:0] f_popcount(input logic [NSLOT-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < NSLOT; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    assign w_pcount = f_popcount(r_pend);

    // Every pending op will need a FIFO slot, so reserve one for each of them.
    // A pop in this same cycle does not free a credit; this keeps the ready
    // path independent of wb_ready_i.
    assign w_credit_ok   = (int'(w_fifo_cnt) + int'(w_pcount)) < FIFO_DEPTH;
    assign issue_ready_o = ~r_pend[issue_delay_i] & w_credit_ok;
    assign w_acc         = issue_valid_i & issue_ready_o;

    // Delay 0 means the lane is combinational, so the result is on the bus in
    // the issue cycle. It can never coincide with r_pend[0] (collision stall).
    assign w_cap     = r_pend[0] | (w_acc & (issue_delay_i == '0));
    assign w_cap_tag = r_pend[0] ? r_tag[0] : issue_tag_i;
    assign w_fifo_din = {w_cap_tag, lane_dout_i};

    always_comb begin
        w_pend_nxt = '0;
        for (int k = 0; k < NSLOT; k++) begin
            w_tag_nxt[k] = '0;
        end
        for (int k = 0; k < NSLOT - 1; k++) begin
            if (w_acc && (issue_delay_i == MAX_DELAY_LG2'(k + 1))) begin
                w_pend_nxt[k] = 1'b1;
                w_tag_nxt[k]  = issue_tag_i;
            end else begin
                w_pend_nxt[k] = r_pend[k + 1];
                w_tag_nxt[k]  = r_tag[k + 1];
            end
        end
        // The top slot could only be loaded by a delay of NSLOT, which the
        // delay field cannot express, so it always shifts in empty.
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_inflight <= '0;
            for (int k = 0; k < NSLOT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_pend     <= w_pend_nxt;
            r_inflight <= f_popcount(w_pend_nxt);
            for (int k = 0; k < NSLOT; k++) begin
                r_tag[k] <= w_tag_nxt[k];
            end
        end
    end

    vpu_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_cap),
        .din_i   (w_fifo_din),
        .pop_i   (wb_valid_o & wb_ready_i),
        .dout_o  (w_fifo_dout),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_cnt)
    );

    assign wb_valid_o = ~w_fifo_empty;
    assign wb_tag_o   = w_fifo_dout[EW-1:OPERAND_WIDTH];
    assign wb_data_o  = w_fifo_dout[OPERAND_WIDTH-1:0];
    assign inflight_o = r_inflight;
    assign busy_o     = (r_inflight != '0) | wb_valid_o;

    // The credit rule guarantees a capture never meets a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_cap && w_fifo_full));

endmodule

// File: tb/tb_vpu_lane_result_collector.sv
module tb_vpu_lane_result_collector;

    localparam int OPW   = 32;
    localparam int DLG   = 3;
    localparam int TGW   = 5;
    localparam int DEPTH = 4;
    localparam int W     = TGW + OPW;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst;
    logic           issue_valid_i;
    logic [DLG-1:0] issue_delay_i;
    logic [TGW-1:0] issue_tag_i;
    logic           issue_ready_o;
    logic [OPW-1:0] lane_dout_i;
    logic           wb_valid_o;
    logic [OPW-1:0] wb_data_o;
    logic [TGW-1:0] wb_tag_o;
    logic           wb_ready_i;
    logic [DLG:0]   inflight_o;
    logic           busy_o;

    always #5 clk = ~clk;

    vpu_lane_result_collector #(
        .OPERAND_WIDTH (OPW),
        .MAX_DELAY_LG2 (DLG),
        .TAG_WIDTH     (TGW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid_i),
        .issue_delay_i (issue_delay_i),
        .issue_tag_i   (issue_tag_i),
        .issue_ready_o (issue_ready_o),
        .lane_dout_i   (lane_dout_i),
        .wb_valid_o    (wb_valid_o),
        .wb_data_o     (wb_data_o),
        .wb_tag_o      (wb_tag_o),
        .wb_ready_i    (wb_ready_i),
        .inflight_o    (inflight_o),
        .busy_o        (busy_o)
    );

    // ---------------- scoreboard / reference model ----------------
    // exp_q: results expected at writeback, in order ({tag, data}).
    // out_time/out_tag: issued ops still waiting for their completion cycle.
    int             n_total = 0;
    int             n_bad   = 0;
    int             cyc     = 0;
    logic [W-1:0]   exp_q[$];
    int             out_time[$];
    logic [TGW-1:0] out_tag[$];
    logic           m_ready;

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic collides(input int d);
        for (int i = 0; i < out_time.size(); i++) begin
            if (out_time[i] == cyc + d) return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic v, input int d, input int t, input logic [31:0] dout,
                          input logic wr, input logic r);
        issue_valid_i = v;
        issue_delay_i = DLG'(d);
        issue_tag_i   = TGW'(t);
        lane_dout_i   = dout;
        wb_ready_i    = wr;
        rst           = r;
    endtask

    // Compare DUT outputs with the model in the middle of the cycle.
    task automatic sample();
        logic [W-1:0] head;
        @(negedge clk);
        m_ready = !collides(int'(issue_delay_i)) &&
                  ((exp_q.size() + out_time.size()) < DEPTH);
        check_val("issue_ready", 64'(issue_ready_o), 64'(m_ready));
        check_val("wb_valid", 64'(wb_valid_o), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check_val("wb_data", 64'(wb_data_o), 64'(head[OPW-1:0]));
            check_val("wb_tag", 64'(wb_tag_o), 64'(head[W-1:OPW]));
        end
        check_val("inflight", 64'(inflight_o), 64'(out_time.size()));
        check_val("busy", 64'(busy_o), 64'((out_time.size() != 0) || (exp_q.size() != 0)));
    endtask

    // Apply the upcoming clock edge to the model, then step the DUT.
    task automatic advance();
        int  idx;
        logic acc;
        if (rst) begin
            exp_q.delete();
            out_time.delete();
            out_tag.delete();
        end else begin
            acc = issue_valid_i && m_ready;
            if (wb_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
            idx = -1;
            for (int i = 0; i < out_time.size(); i++) begin
                if (out_time[i] == cyc) idx = i;
            end
            if (idx >= 0) begin
                exp_q.push_back({out_tag[idx], lane_dout_i});
                out_time.delete(idx);
                out_tag.delete(idx);
            end
            if (acc && issue_delay_i == 0) exp_q.push_back({issue_tag_i, lane_dout_i});
            if (acc && issue_delay_i != 0) begin
                out_time.push_back(cyc + int'(issue_delay_i));
                out_tag.push_back(issue_tag_i);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic           pend_v;
        int             pend_d;
        int             pend_t;
        logic           wr;
        logic [31:0]    dout;

        set_in(1'b0, 0, 0, 32'h0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        set_in(1'b0, 0, 0, 32'h0, 1'b0, 1'b0);
        sample();
        check_val("rst_wb_data", 64'(wb_data_o), 64'h0);
        check_val("rst_wb_tag", 64'(wb_tag_o), 64'h0);
        advance();

        // 1: reset mid-flight drops the op
        set_in(1'b1, 3, 1, 32'h11, 1'b1, 1'b0); sample(); advance();
        set_in(1'b0, 0, 0, 32'h22, 1'b1, 1'b1); sample(); advance();
        for (int s = 0; s < 6; s++) begin
            set_in(1'b0, 0, 0, $urandom, 1'b1, 1'b0);
            sample();
            check_val("t1_wb_valid", 64'(wb_valid_o), 64'h0);
            check_val("t1_wb_data", 64'(wb_data_o), 64'h0);
            check_val("t1_inflight", 64'(inflight_o), 64'h0);
            check_val("t1_busy", 64'(busy_o), 64'h0);
            advance();
        end

        // 2: delay 0 sampled in the issue cycle
        set_in(1'b1, 0, 7, 32'h3F800000, 1'b1, 1'b0);
        sample();
        check_val("t2_ready", 64'(issue_ready_o), 64'h1);
        advance();
        set_in(1'b0, 0, 0, 32'h0, 1'b1, 1'b0);
        sample();
        check_val("t2_wb_valid", 64'(wb_valid_o), 64'h1);
        check_val("t2_wb_data", 64'(wb_data_o), 64'h3F800000);
        check_val("t2_wb_tag", 64'(wb_tag_o), 64'h7);
        advance();
        set_in(1'b0, 0, 0, 32'h0, 1'b1, 1'b0);
        sample();
        check_val("t2_one_cycle", 64'(wb_valid_o), 64'h0);
        advance();

        // 3: completion order, not issue order
        for (int s = 0; s < 7; s++) begin
            dout = 32'hA0 + 32'(s);
            case (s)
                0:       set_in(1'b1, 4, 1, dout, 1'b1, 1'b0);
                1:       set_in(1'b1, 1, 2, dout, 1'b1, 1'b0);
                default: set_in(1'b0, 0, 0, dout, 1'b1, 1'b0);
            endcase
            sample();
            if (s == 3) begin
                check_val("t3_first_tag", 64'(wb_tag_o), 64'h2);
                check_val("t3_first_data", 64'(wb_data_o), 64'hA2);
            end
            if (s == 4) check_val("t3_gap", 64'(wb_valid_o), 64'h0);
            if (s == 5) begin
                check_val("t3_second_tag", 64'(wb_tag_o), 64'h1);
                check_val("t3_second_data", 64'(wb_data_o), 64'hA4);
            end
            advance();
        end

        // 4: collision stall, held request accepted next cycle
        for (int s = 0; s < 7; s++) begin
            dout = 32'hB0 + 32'(s);
            case (s)
                0:       set_in(1'b1, 3, 1, dout, 1'b1, 1'b0);
                1, 2:    set_in(1'b1, 2, 2, dout, 1'b1, 1'b0);
                default: set_in(1'b0, 0, 0, dout, 1'b1, 1'b0);
            endcase
            sample();
            if (s == 1) check_val("t4_collide", 64'(issue_ready_o), 64'h0);
            if (s == 2) check_val("t4_accept", 64'(issue_ready_o), 64'h1);
            if (s == 4) begin
                check_val("t4_tag1", 64'(wb_tag_o), 64'h1);
                check_val("t4_data1", 64'(wb_data_o), 64'hB3);
            end
            if (s == 5) begin
                check_val("t4_tag2", 64'(wb_tag_o), 64'h2);
                check_val("t4_data2", 64'(wb_data_o), 64'hB4);
            end
            advance();
        end

        // 5: backpressure and credit stall
        for (int s = 0; s < 13; s++) begin
            dout = 32'hC0 + 32'(s);
            set_in(s <= 8, 1, (s < 4) ? 10 + s : 14, dout, s >= 7, 1'b0);
            if (s > 8) issue_valid_i = 1'b0;
            sample();
            if (s < 4) check_val("t5_ready_open", 64'(issue_ready_o), 64'h1);
            if (s >= 4 && s <= 7) check_val("t5_ready_stall", 64'(issue_ready_o), 64'h0);
            if (s >= 5 && s <= 7) begin
                check_val("t5_head_tag", 64'(wb_tag_o), 64'd10);
                check_val("t5_head_data", 64'(wb_data_o), 64'hC1);
            end
            if (s == 8) begin
                check_val("t5_ready_back", 64'(issue_ready_o), 64'h1);
                check_val("t5_pop_tag11", 64'(wb_tag_o), 64'd11);
            end
            if (s == 9)  check_val("t5_pop_tag12", 64'(wb_tag_o), 64'd12);
            if (s == 10) check_val("t5_pop_tag13", 64'(wb_tag_o), 64'd13);
            if (s == 11) begin
                check_val("t5_pop_tag14", 64'(wb_tag_o), 64'd14);
                check_val("t5_data14", 64'(wb_data_o), 64'hC9);
            end
            advance();
        end

        // 6: random traffic against the model
        pend_v = 1'b0;
        pend_d = 0;
        pend_t = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!pend_v && $urandom_range(0, 1) == 1) begin
                pend_v = 1'b1;
                pend_d = $urandom_range(0, 7);
                pend_t = $urandom_range(0, 31);
            end
            wr = ($urandom_range(0, 3) != 0);
            set_in(pend_v, pend_d, pend_t, $urandom, wr, 1'b0);
            sample();
            if (pend_v && m_ready) pend_v = 1'b0;
            advance();
        end
        for (int i = 0; i < 20; i++) begin
            set_in(1'b0, 0, 0, $urandom, 1'b1, 1'b0);
            sample();
            advance();
        end
        check_val("t6_drained_valid", 64'(wb_valid_o), 64'h0);
        check_val("t6_drained_inflight", 64'(inflight_o), 64'h0);
        check_val("t6_drained_busy", 64'(busy_o), 64'h0);

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
